// File: rtl/teleport_sequencer.sv
// Teleport sequence for Bumpy landing on a PORT tile: fade-out, jump, fade-in, cooldown.
// Optional macro TELEPORT_CENTER_EN centres the sprite inside the destination tile.
module teleport_sequencer #(
    parameter int unsigned NUM_OF_ROWS     = 7,
    parameter int unsigned NUM_OF_COLS     = 10,
    parameter int unsigned TILE_SHIFT      = 6,
    parameter int unsigned FADE_FRAMES     = 8,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned OBJ_SIZE        = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        land,
    input  logic [2:0]  tile_type,
    input  logic [7:0]  teleport_cordinates,
    output logic        teleport_pulse,
    output logic [10:0] new_bumpy_x,
    output logic [10:0] new_bumpy_y,
    output logic [3:0]  fade_level,
    output logic        busy,
    output logic        coord_error
);

    localparam int unsigned MAX_FRAMES = (FADE_FRAMES > COOLDOWN_FRAMES) ? FADE_FRAMES : COOLDOWN_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam logic [2:0]  PORT       = 3'b100;
`ifdef TELEPORT_CENTER_EN
    localparam bit          CENTER_EN  = 1'b1;
`else
    localparam bit          CENTER_EN  = 1'b0;
`endif
    localparam int unsigned OFFSET     = CENTER_EN ? (((1 << TILE_SHIFT) - OBJ_SIZE) / 2) : 0;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        JUMP,
        FADE_IN,
        COOLDOWN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dest_x;
    logic [3:0]       dest_y;

    logic             coord_valid_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [10:0]      pix_x_c;
    logic [10:0]      pix_y_c;

    // Linear visibility ramp 0..15 over FADE_FRAMES frames
    function automatic logic [3:0] ramp(input logic [CNT_W-1:0] n);
        ramp = 4'((32'd15 * 32'(n)) / FADE_FRAMES);
    endfunction

    assign coord_valid_c = (32'(teleport_cordinates[7:4]) < NUM_OF_COLS) &&
                           (32'(teleport_cordinates[3:0]) < NUM_OF_ROWS);
    assign cnt_inc_c     = cnt + CNT_W'(1);
    assign pix_x_c       = (11'(dest_x) << TILE_SHIFT) + 11'(OFFSET);
    assign pix_y_c       = (11'(dest_y) << TILE_SHIFT) + 11'(OFFSET);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            cnt            <= '0;
            dest_x         <= '0;
            dest_y         <= '0;
            teleport_pulse <= 1'b0;
            new_bumpy_x    <= '0;
            new_bumpy_y    <= '0;
            fade_level     <= 4'd15;
            busy           <= 1'b0;
            coord_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A frame pulse coinciding with an accepted land is not counted
                    if (land && tile_type == PORT) begin
                        dest_x <= teleport_cordinates[7:4];
                        dest_y <= teleport_cordinates[3:0];
                        if (coord_valid_c) begin
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= FADE_OUT;
                        end else begin
                            coord_error <= 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (startOfFrame) begin
                        if (cnt_inc_c == CNT_W'(FADE_FRAMES)) begin
                            cnt            <= '0;
                            fade_level     <= 4'd0;
                            teleport_pulse <= 1'b1;
                            new_bumpy_x    <= pix_x_c;
                            new_bumpy_y    <= pix_y_c;
                            state          <= JUMP;
                        end else begin
                            cnt        <= cnt_inc_c;
                            fade_level <= 4'd15 - ramp(cnt_inc_c);
                        end
                    end
                end
                JUMP: begin
                    teleport_pulse <= 1'b0;
                    cnt            <= '0;
                    state          <= FADE_IN;
                end
                FADE_IN: begin
                    if (startOfFrame) begin
                        if (cnt_inc_c == CNT_W'(FADE_FRAMES)) begin
                            cnt        <= '0;
                            fade_level <= 4'd15;
                            state      <= COOLDOWN;
                        end else begin
                            cnt        <= cnt_inc_c;
                            fade_level <= ramp(cnt_inc_c);
                        end
                    end
                end
                COOLDOWN: begin
                    // Blocks re-trigger from the destination PORT tile
                    if (startOfFrame) begin
                        if (cnt_inc_c == CNT_W'(COOLDOWN_FRAMES)) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt_inc_c;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teleport_sequencer.sv
// Self-checking bench for teleport_sequencer: vector table, directed sequences,
// and randomized traffic against a frame-count reference model.
module tb_teleport_sequencer;

    localparam int FF    = 8;
    localparam int CF    = 30;
    localparam int TILE  = 64;
`ifdef TELEPORT_CENTER_EN
    localparam int OFS   = 16;
`else
    localparam int OFS   = 0;
`endif

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        land;
    logic [2:0]  tile_type;
    logic [7:0]  teleport_cordinates;
    logic        teleport_pulse;
    logic [10:0] new_bumpy_x;
    logic [10:0] new_bumpy_y;
    logic [3:0]  fade_level;
    logic        busy;
    logic        coord_error;

    teleport_sequencer dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .land                (land),
        .tile_type           (tile_type),
        .teleport_cordinates (teleport_cordinates),
        .teleport_pulse      (teleport_pulse),
        .new_bumpy_x         (new_bumpy_x),
        .new_bumpy_y         (new_bumpy_y),
        .fade_level          (fade_level),
        .busy                (busy),
        .coord_error         (coord_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: one frame count g spans the whole sequence after acceptance
    bit          m_active;
    int          m_g;
    int          m_dx, m_dy;
    logic        m_pulse;
    logic [10:0] m_x, m_y;
    logic [3:0]  m_fade;
    logic        m_busy, m_err;

    typedef struct {
        logic [2:0] tt;
        logic [7:0] c;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_g = 0; m_dx = 0; m_dy = 0;
        m_pulse = 1'b0; m_x = '0; m_y = '0; m_fade = 4'd15;
        m_busy = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic l, input logic [2:0] t, input logic [7:0] c);
        if (!m_active) begin
            if (l && t == 3'b100) begin
                m_dx = int'(c[7:4]);
                m_dy = int'(c[3:0]);
                if (m_dx < 10 && m_dy < 7) begin
                    m_active = 1; m_g = 0; m_busy = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_pulse) begin
            m_pulse = 1'b0;
        end else if (s) begin
            m_g++;
            if (m_g <= FF) begin
                m_fade = 4'(15 - (15 * m_g) / FF);
                if (m_g == FF) begin
                    m_pulse = 1'b1;
                    m_x = 11'(m_dx * TILE + OFS);
                    m_y = 11'(m_dy * TILE + OFS);
                end
            end else if (m_g <= 2 * FF) begin
                m_fade = 4'((15 * (m_g - FF)) / FF);
            end else if (m_g == 2 * FF + CF) begin
                m_active = 0;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string name);
        chk({name, "_pulse"}, int'(teleport_pulse), int'(m_pulse));
        chk({name, "_x"},     int'(new_bumpy_x),    int'(m_x));
        chk({name, "_y"},     int'(new_bumpy_y),    int'(m_y));
        chk({name, "_fade"},  int'(fade_level),     int'(m_fade));
        chk({name, "_busy"},  int'(busy),           int'(m_busy));
        chk({name, "_err"},   int'(coord_error),    int'(m_err));
    endtask

    task automatic step(input logic s, input logic l, input logic [2:0] t, input logic [7:0] c);
        startOfFrame = s; land = l; tile_type = t; teleport_cordinates = c;
        @(posedge clk);
        model_step(s, l, t, c);
        #1;
        if (teleport_pulse) pulses++;
        compare_all("cyc");
        startOfFrame = 1'b0; land = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 3'd0, 8'h00);
            step(1'b0, 1'b0, 3'd0, 8'h00);
            step(1'b1, 1'b0, 3'd0, 8'h00);
        end
    endtask

    task automatic apply_reset();
        startOfFrame = 1'b0; land = 1'b0;
        #2 resetN = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        @(negedge clk) resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; land = 1'b0;
        tile_type = 3'd0; teleport_cordinates = 8'h00;
        model_reset();

        vecs[0] = '{3'b100, 8'h76, 1'b1, 1'b0};
        vecs[1] = '{3'b101, 8'h76, 1'b0, 1'b0};
        vecs[2] = '{3'b100, 8'hF0, 1'b0, 1'b1};
        vecs[3] = '{3'b100, 8'h96, 1'b1, 1'b0};
        vecs[4] = '{3'b100, 8'hA0, 1'b0, 1'b1};
        vecs[5] = '{3'b100, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{3'b100, 8'h06, 1'b1, 1'b0};
        vecs[7] = '{3'b000, 8'h11, 1'b0, 1'b0};
        vecs[8] = '{3'b100, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{3'b011, 8'h22, 1'b0, 1'b0};

        @(negedge clk);
        apply_reset();

        // Single-cycle response to a land from IDLE
        foreach (vecs[i]) begin
            apply_reset();
            step(1'b0, 1'b1, vecs[i].tt, vecs[i].c);
            chk("vec_busy",  int'(busy),           int'(vecs[i].exp_busy));
            chk("vec_err",   int'(coord_error),    int'(vecs[i].exp_err));
            chk("vec_pulse", int'(teleport_pulse), 0);
            chk("vec_fade",  int'(fade_level),     15);
        end

        // Full teleport to 8'h76, then cooldown drop and a second teleport to 8'h16
        apply_reset();
        pulses = 0;
        step(1'b1, 1'b1, 3'b100, 8'h76);
        chk("t1_busy", int'(busy), 1);
        frames(FF - 1);
        chk("t1_prepulse", pulses, 0);
        frames(1);
        chk("t1_pulse", int'(teleport_pulse), 1);
        chk("t1_x", int'(new_bumpy_x), 448 + OFS);
        chk("t1_y", int'(new_bumpy_y), 384 + OFS);
        chk("t1_fade0", int'(fade_level), 0);
        step(1'b1, 1'b0, 3'd0, 8'h00);
        chk("t1_pulse_len", int'(teleport_pulse), 0);
        frames(FF);
        chk("t1_fade15", int'(fade_level), 15);
        chk("t1_cool_busy", int'(busy), 1);
        frames(5);
        step(1'b0, 1'b1, 3'b100, 8'h16);
        chk("t4_drop_x", int'(new_bumpy_x), 448 + OFS);
        frames(CF - 6);
        chk("t4_cool_busy", int'(busy), 1);
        frames(1);
        chk("t4_idle", int'(busy), 0);
        step(1'b0, 1'b1, 3'b100, 8'h16);
        frames(FF);
        chk("t4_pulse", int'(teleport_pulse), 1);
        chk("t4_x", int'(new_bumpy_x), 64 + OFS);
        chk("t4_y", int'(new_bumpy_y), 384 + OFS);
        chk("t4_pulses", pulses, 2);
        step(1'b0, 1'b0, 3'd0, 8'h00);
        frames(FF + CF);

        // Invalid destination is sticky and leaves the position untouched
        step(1'b0, 1'b1, 3'b100, 8'hF0);
        chk("t3_err", int'(coord_error), 1);
        chk("t3_busy", int'(busy), 0);
        chk("t3_x", int'(new_bumpy_x), 64 + OFS);
        step(1'b0, 1'b1, 3'b101, 8'h22);
        chk("t3_sticky", int'(coord_error), 1);

        // Asynchronous reset at frame 4 of the fade-out
        step(1'b0, 1'b1, 3'b100, 8'h76);
        frames(4);
        apply_reset();
        chk("t5_busy", int'(busy), 0);
        chk("t5_fade", int'(fade_level), 15);
        pulses = 0;
        frames(20);
        chk("t5_nopulse", pulses, 0);

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 8000; i++) begin
            logic       s, l;
            logic [2:0] t;
            logic [7:0] c;
            s = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom_range(0, 7));
            c = 8'($urandom);
            step(s, l, t, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
